acc_share_arbiter: RTL and testbench
====================================

Name: acc_share_arbiter

Overview:
Shares one acc_pipe 4-input neuron accelerator between N_REQ requesters. The block performs round-robin arbitration of input vectors into the accelerator. An in-order tag FIFO records which requester owns each in-flight vector. Each result is routed back to the requester that issued it. A flush FSM drains the pipeline on demand. The block sits between the requester ports and the accelerator's valid/ready interfaces.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, signed data width of X and Y
DEPTH, 8, max in-flight vectors (tag FIFO depth, power of 2)
TAG_W, $clog2(N_REQ), requester index width (localparam)

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  per-requester input valid
req_ready  out  N_REQ  per-requester input accepted
req_x  in  N_REQ*4*DW  per requester {X4,X3,X2,X1}; requester k occupies bits [k*4*DW +: 4*DW]
rsp_valid  out  N_REQ  one-hot result valid
rsp_ready  in  N_REQ  per-requester result accept
rsp_y  out  DW  shared signed result bus
acc_x1..acc_x4  out  DW each  to accelerator X1..X4
acc_valid  out  1  to accelerator valid
acc_ready  in  1  from accelerator ready
acc_y  in  DW  from accelerator Y
acc_valid_out  in  1  from accelerator valid_out
acc_ready_out  out  1  to accelerator ready_out
flush  in  1  request drain
flush_done  out  1  pipeline empty, issue halted
err  out  1  sticky protocol error

Behaviour:
- Reset (arst=1, async): rr_ptr=0, FIFO empty (count=0), state=RUN, err=0, flush_done=0. All valid/ready outputs are 0 while reset is held. The accelerator shares arst, so in-flight data is discarded.
- Arbitration is combinational. Grant goes to the first k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, … mod N_REQ.
- Issue conditions: state==RUN, some req_valid, FIFO not full.
- On issue: acc_valid=1 and acc_x* = req_x slice of the granted requester.
- req_ready[g] = issue && acc_ready. All other req_ready bits are 0.
- Handshake: acc_valid && acc_ready in a cycle. At that rising edge:
  - push g into the FIFO;
  - rr_ptr <= (g+1) mod N_REQ.
- rr_ptr is unchanged when nothing is granted.
- acc_valid depends only on req_valid, state and FIFO fullness, never on acc_ready. No combinational path acc_ready -> acc_valid.
- Response path (head tag h, FIFO not empty):
  - rsp_valid[h] = acc_valid_out;
  - rsp_y = acc_y;
  - acc_ready_out = rsp_ready[h].
- Pop the FIFO on acc_valid_out && acc_ready_out.
- FIFO empty: acc_ready_out=0 and rsp_valid=0. If acc_valid_out=1 while empty, err<=1 (sticky until reset).
- Full boundary: count==DEPTH blocks issue, even when a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged, pointers both advance.
- Latency: adds no cycles. The request->accelerator path and the accelerator->response path are both combinational.
- FSM:
  - RUN -> DRAIN when flush=1.
  - DRAIN: no issue. -> DONE when count==0, including the count after that cycle's pop.
  - DONE: flush_done=1. -> RUN when flush=0.
  - Responses keep draining in every state.

Optional Feature:
- Macro: ACC_ARB_STATS_EN.
- Defined: adds output grant_cnt (N_REQ*16 bits). It holds per-requester 16-bit saturating counters, incremented on each accepted issue. Counters reset to 0 by arst and also clear on entry to DONE.
- Also adds output inflight (log2(DEPTH)+1 bits), equal to the FIFO count.
- Undefined: neither port exists and there is no counter logic. The functional behaviour is otherwise identical.

Decomposition:
- Package acc_arb_pkg: DW, default DEPTH, state enum {RUN, DRAIN, DONE}, helper function rr_pick(valid, ptr) returning the grant index.
- One sub-module: acc_tag_fifo (parameters DEPTH, TAG_W; push/pop/full/empty/count/head). It is instantiated once.
- Arbiter, response routing and FSM stay in acc_share_arbiter.

Test Plan:
- Single requester: req_valid=4'b0100 with X=(1,2,3,4), accelerator ready. Expected: acc_x matches; req_ready=4'b0100; rr_ptr becomes 3; the result appears with rsp_valid=4'b0100 and rsp_y=acc_y.
- Fairness: all 4 requesters valid continuously for 8 accepted issues from reset. Expected grant order 0,1,2,3,0,1,2,3, and each result returned to its owner in that order.
- Backpressure, DEPTH=8:
  - Hold acc_ready_out low via rsp_ready=0: after 8 issues, acc_valid=0 with req_valid still high.
  - A pop in the same cycle as full still blocks issue.
  - Releasing rsp_ready resumes issue one cycle later.
- Flush: assert flush with 3 vectors in flight. Expected: no further acc_valid, 3 responses delivered, then flush_done=1. Deasserting flush returns to RUN and issue resumes.
- Error and reset:
  - acc_valid_out=1 while the FIFO is empty: err=1 and stays set.
  - arst pulse mid-stream: all outputs 0 immediately; rr_ptr=0; err=0; FIFO empty.
- Stats (ACC_ARB_STATS_EN): 70000 grants to requester 0. Expected grant_cnt[0]=16'hFFFF; inflight tracks count.

Source files
------------

// File: rtl/acc_arb_pkg.sv
// rtl/acc_arb_pkg.sv - shared defaults, FSM state type and round-robin pick for acc_share_arbiter
package acc_arb_pkg;

  localparam int ARB_DW      = 8;
  localparam int ARB_DEPTH   = 8;
  localparam int ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} arb_state_t;

  // First set bit of valid at or after ptr, wrapping modulo n; returns ptr when none set.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    int idx;
    pick = ptr;
    for (int i = ARB_MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (valid[idx]) pick = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/acc_tag_fifo.sv
// rtl/acc_tag_fifo.sv - in-order FIFO of requester tags for vectors in flight in the accelerator
module acc_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [TAG_W-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/acc_share_arbiter.sv
// rtl/acc_share_arbiter.sv - round-robin sharing of one acc_pipe accelerator with tag-routed results and flush FSM
// Optional ACC_ARB_STATS_EN adds per-requester grant counters (grant_cnt) and FIFO occupancy (inflight).
module acc_share_arbiter
  import acc_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = ARB_DW,
  parameter int DEPTH = ARB_DEPTH
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*4*DW-1:0]       req_x,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic signed [DW-1:0]        rsp_y,
  output logic signed [DW-1:0]        acc_x1,
  output logic signed [DW-1:0]        acc_x2,
  output logic signed [DW-1:0]        acc_x3,
  output logic signed [DW-1:0]        acc_x4,
  output logic                        acc_valid,
  input  logic                        acc_ready,
  input  logic signed [DW-1:0]        acc_y,
  input  logic                        acc_valid_out,
  output logic                        acc_ready_out,
`ifdef ACC_ARB_STATS_EN
  output logic [N_REQ*16-1:0]         grant_cnt,
  output logic [$clog2(DEPTH):0]      inflight,
`endif
  input  logic                        flush,
  output logic                        flush_done,
  output logic                        err
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int CW    = $clog2(DEPTH) + 1;

  arb_state_t       state;
  arb_state_t       state_next;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             issue;
  logic             push;
  logic             pop;
  logic [4*DW-1:0]  x_sel;

  assign grant = TAG_W'(rr_pick(8'(req_valid), 3'(rr_ptr), N_REQ));
  // acc_ready must stay out of issue so acc_valid never depends on it.
  assign issue = !arst && (state == RUN) && (|req_valid) && !full;
  assign push  = issue && acc_ready;
  assign pop   = acc_valid_out && acc_ready_out;

  assign x_sel     = req_x[grant*4*DW +: 4*DW];
  assign acc_x1    = x_sel[DW-1:0];
  assign acc_x2    = x_sel[2*DW-1:DW];
  assign acc_x3    = x_sel[3*DW-1:2*DW];
  assign acc_x4    = x_sel[4*DW-1:3*DW];
  assign acc_valid = issue;
  assign rsp_y     = acc_y;

  always_comb begin
    req_ready = '0;
    if (push) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rsp_valid     = '0;
    acc_ready_out = 1'b0;
    if (!empty) begin
      rsp_valid[head] = acc_valid_out;
      acc_ready_out   = rsp_ready[head];
    end
  end

  acc_tag_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_tag_fifo (
    .clk      (clk),
    .arst     (arst),
    .push     (push),
    .push_tag (grant),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
  );

  always_comb begin
    state_next = state;
    flush_done = (state == DONE);
    case (state)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (count == '0 || (count == CW'(1) && pop)) state_next = DONE;
      DONE:    if (!flush) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= RUN;
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_next;
      if (push) rr_ptr <= (grant == TAG_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
      if (acc_valid_out && empty) err <= 1'b1;
    end
  end

`ifdef ACC_ARB_STATS_EN
  logic [15:0] cnt [N_REQ];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < N_REQ; k++) cnt[k] <= '0;
    end else if (state_next == DONE && state != DONE) begin
      for (int k = 0; k < N_REQ; k++) cnt[k] <= '0;
    end else if (push && cnt[grant] != 16'hFFFF) begin
      cnt[grant] <= cnt[grant] + 16'd1;
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
    assign grant_cnt[k*16 +: 16] = cnt[k];
  end
  assign inflight = count;
`endif

endmodule

// File: tb/tb_acc_share_arbiter.sv
// tb/tb_acc_share_arbiter.sv - self-checking bench for acc_share_arbiter (queue-based model plus directed literals)
module tb_acc_share_arbiter;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_x = '0;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready = '0;
  logic [7:0]   rsp_y;
  logic [7:0]   acc_x1, acc_x2, acc_x3, acc_x4;
  logic         acc_valid;
  logic         acc_ready = 1'b0;
  logic [7:0]   acc_y = '0;
  logic         acc_valid_out = 1'b0;
  logic         acc_ready_out;
  logic         flush = 1'b0;
  logic         flush_done;
  logic         err;
`ifdef ACC_ARB_STATS_EN
  logic [63:0]  grant_cnt;
  logic [3:0]   inflight;
`endif

  acc_share_arbiter #(.N_REQ(4), .DW(8), .DEPTH(8)) dut (
    .clk           (clk),
    .arst          (arst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_y         (rsp_y),
    .acc_x1        (acc_x1),
    .acc_x2        (acc_x2),
    .acc_x3        (acc_x3),
    .acc_x4        (acc_x4),
    .acc_valid     (acc_valid),
    .acc_ready     (acc_ready),
    .acc_y         (acc_y),
    .acc_valid_out (acc_valid_out),
    .acc_ready_out (acc_ready_out),
`ifdef ACC_ARB_STATS_EN
    .grant_cnt     (grant_cnt),
    .inflight      (inflight),
`endif
    .flush         (flush),
    .flush_done    (flush_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: requester owning each in-flight vector, in issue order.
  int mq[$];
  int m_ptr = 0;
  int m_state = 0;  // 0 running, 1 draining, 2 flush complete
  bit m_err = 1'b0;
  int m_cnt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int g, h;
    logic e_av, e_push, e_aro, e_pop;
    logic [3:0] e_rr, e_rv;
    if (arst) begin
      m_ptr = 0; mq.delete(); m_state = 0; m_err = 1'b0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      chk("rst_acc_valid", 64'(acc_valid), 0);
      chk("rst_req_ready", 64'(req_ready), 0);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_acc_ready_out", 64'(acc_ready_out), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_flush_done", 64'(flush_done), 0);
    end else begin
      g = -1;
      for (int i = 0; i < 4; i++) if (g < 0 && req_valid[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
      e_av   = (m_state == 0) && (g >= 0) && (mq.size() < 8);
      e_push = e_av && acc_ready;
      e_rr   = e_push ? 4'(1 << g) : 4'b0;
      e_rv   = 4'b0;
      e_aro  = 1'b0;
      if (mq.size() > 0) begin
        h = mq[0];
        e_aro = rsp_ready[h];
        if (acc_valid_out) e_rv = 4'(1 << h);
      end
      e_pop = acc_valid_out && e_aro;
      chk("m_acc_valid", 64'(acc_valid), 64'(e_av));
      chk("m_req_ready", 64'(req_ready), 64'(e_rr));
      chk("m_rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("m_acc_ready_out", 64'(acc_ready_out), 64'(e_aro));
      chk("m_rsp_y", 64'(rsp_y), 64'(acc_y));
      chk("m_err", 64'(err), 64'(m_err));
      chk("m_flush_done", 64'(flush_done), 64'(m_state == 2));
      if (e_av) chk("m_acc_x", 64'({acc_x4, acc_x3, acc_x2, acc_x1}), 64'(req_x[g*32 +: 32]));
`ifdef ACC_ARB_STATS_EN
      chk("m_inflight", 64'(inflight), 64'(mq.size()));
      chk("m_grant_cnt", grant_cnt, {16'(m_cnt[3]), 16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])});
`endif
      if (acc_valid_out && mq.size() == 0) m_err = 1'b1;
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin
        mq.push_back(g);
        m_ptr = (g + 1) % 4;
        if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
      end
      if (m_state == 0 && flush) m_state = 1;
      else if (m_state == 1 && mq.size() == 0) begin
        m_state = 2;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else if (m_state == 2 && !flush) m_state = 0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    cyc();
    cyc();
    arst = 1'b0;
  endtask

  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int g_log[8];
  int r_log[8];

  initial begin
    for (int k = 0; k < 4; k++)
      req_x[k*32 +: 32] = {8'(k*16+4), 8'(k*16+3), 8'(k*16+2), 8'(k*16+1)};
    req_x[64 +: 32] = 32'h04030201;
    req_valid = 4'hF;
    acc_ready = 1'b1;
    rsp_ready = 4'hF;
    #2;
    chk("reset_acc_valid", 64'(acc_valid), 0);
    chk("reset_req_ready", 64'(req_ready), 0);
    cyc();
    cyc();
    req_valid = 4'b0;
    rsp_ready = 4'b0;
    arst = 1'b0;

    // single requester
    req_valid = 4'b0100;
    #1;
    chk("single_acc_x", 64'({acc_x4, acc_x3, acc_x2, acc_x1}), 64'h04030201);
    chk("single_req_ready", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = 4'b0; acc_valid_out = 1'b1; acc_y = 8'hFB; rsp_ready = 4'b0100;
    #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'b0100);
    chk("single_rsp_y", 64'(rsp_y), 64'hFB);
    chk("single_acc_ready_out", 64'(acc_ready_out), 1);
    cyc();
    req_valid = 4'hF; acc_valid_out = 1'b0;
    #1;
    chk("single_next_ptr3", 64'(req_ready), 64'b1000);
    cyc();
    req_valid = 4'b0; acc_valid_out = 1'b1; rsp_ready = 4'hF;
    #1;
    chk("single2_rsp_valid", 64'(rsp_valid), 64'b1000);
    cyc();
    acc_valid_out = 1'b0;

    // fairness
    do_reset();
    req_valid = 4'hF; acc_ready = 1'b1; rsp_ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      g_log[i] = oh_idx(req_ready);
      cyc();
    end
    req_valid = 4'b0; acc_valid_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc_y = 8'(i * 7 + 1);
      #1;
      r_log[i] = oh_idx(rsp_valid);
      cyc();
    end
    acc_valid_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fair_grant", 64'(g_log[i]), 64'(exp_order[i]));
      chk("fair_owner", 64'(r_log[i]), 64'(exp_order[i]));
    end

    // backpressure to full
    do_reset();
    req_valid = 4'b0001; acc_ready = 1'b1; rsp_ready = 4'b0; acc_valid_out = 1'b0;
    repeat (8) cyc();
    #1;
    chk("full_blocks_issue", 64'(acc_valid), 0);
    cyc();
    acc_valid_out = 1'b1; rsp_ready = 4'b0001;
    #1;
    chk("full_pop_still_blocks", 64'(acc_valid), 0);
    chk("full_pop_ready_out", 64'(acc_ready_out), 1);
    cyc();
    #1;
    chk("resume_acc_valid", 64'(acc_valid), 1);
    chk("resume_req_ready", 64'(req_ready), 64'b0001);
    cyc();
    req_valid = 4'b0;
    repeat (7) cyc();
    acc_valid_out = 1'b0;

    // flush with three in flight
    do_reset();
    req_valid = 4'b0011; acc_ready = 1'b1; rsp_ready = 4'hF;
    repeat (3) cyc();
    req_valid = 4'b0; flush = 1'b1;
    cyc();
    req_valid = 4'b0011; acc_valid_out = 1'b1;
    #1;
    chk("drain_no_issue", 64'(acc_valid), 0);
    chk("drain_not_done", 64'(flush_done), 0);
    repeat (3) cyc();
    acc_valid_out = 1'b0;
    #1;
    chk("flush_done_set", 64'(flush_done), 1);
    chk("done_no_issue", 64'(acc_valid), 0);
    flush = 1'b0;
    #1;
    chk("done_until_edge", 64'(flush_done), 1);
    cyc();
    #1;
    chk("run_resume", 64'(acc_valid), 1);
    chk("run_not_done", 64'(flush_done), 0);
    cyc();
    req_valid = 4'b0; acc_valid_out = 1'b1;
    cyc();
    acc_valid_out = 1'b0;

    // protocol error and mid-stream reset
    do_reset();
    acc_valid_out = 1'b1;
    #1;
    chk("err_before_edge", 64'(err), 0);
    cyc();
    acc_valid_out = 1'b0;
    #1;
    chk("err_set", 64'(err), 1);
    repeat (3) cyc();
    chk("err_sticky", 64'(err), 1);
    req_valid = 4'hF; acc_ready = 1'b1; rsp_ready = 4'hF;
    cyc();
    cyc();
    #2;
    arst = 1'b1;
    #1;
    chk("arst_acc_valid", 64'(acc_valid), 0);
    chk("arst_req_ready", 64'(req_ready), 0);
    chk("arst_err", 64'(err), 0);
    chk("arst_flush_done", 64'(flush_done), 0);
    cyc();
    arst = 1'b0;
    #1;
    chk("post_arst_ptr0", 64'(req_ready), 64'b0001);
    chk("post_arst_empty", 64'(acc_ready_out), 0);
    cyc();
    req_valid = 4'b0; acc_valid_out = 1'b1;
    cyc();
    acc_valid_out = 1'b0;

`ifdef ACC_ARB_STATS_EN
    do_reset();
    req_valid = 4'b0001; acc_ready = 1'b1; rsp_ready = 4'hF; acc_valid_out = 1'b0;
    cyc();
    acc_valid_out = 1'b1;
    repeat (70000) cyc();
    chk("stats_sat0", 64'(grant_cnt[15:0]), 64'hFFFF);
    chk("stats_others", 64'(grant_cnt[63:16]), 0);
    chk("stats_inflight", 64'(inflight), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
